// File: rtl/slim_death_sched_pkg.sv
// Shared types and constants for the slime death-animation scheduler.
// The sprite frame map is fixed at seven steps; the step counter never indexes past it.
package slim_pkg;

    localparam int NUM_SLIMES = 3;
    localparam int ID_W       = 2;
    localparam int STEP_W     = 3;
    localparam int TICK_W     = 6;
    localparam int FRAME_W    = 3;

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        PENDING = 2'd1,
        DYING   = 2'd2,
        GONE    = 2'd3
    } slime_state_t;

    localparam logic [FRAME_W-1:0] FRAME_MAP [0:6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

    // Next slime index, wrapping modulo NUM_SLIMES.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id >= ID_W'(NUM_SLIMES - 1)) ? '0 : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/slim_death_sched_if.sv
// Kill/level-start inputs and animation outputs between the game logic and the scheduler.
interface slim_death_sched_if;

    logic                                level_start;
    logic [slim_pkg::NUM_SLIMES-1:0]     kill;
    logic [slim_pkg::NUM_SLIMES-1:0]     display;
    logic [slim_pkg::NUM_SLIMES-1:0]     gone;
    logic [slim_pkg::FRAME_W-1:0]        frame;
    logic [slim_pkg::ID_W-1:0]           active_id;
    logic                                anim_busy;
    logic                                anim_done;

    modport master (
        output level_start,
        output kill,
        input  display,
        input  gone,
        input  frame,
        input  active_id,
        input  anim_busy,
        input  anim_done
    );

    modport slave (
        input  level_start,
        input  kill,
        output display,
        output gone,
        output frame,
        output active_id,
        output anim_busy,
        output anim_done
    );

endinterface

// File: rtl/slim_death_sched_rr_arb.sv
// Combinational round-robin picker over three request lines.
// The pointer register lives in the parent; an out-of-range pointer scans from slime 0.
module slim_rr_arb
    import slim_pkg::*;
(
    input  logic [NUM_SLIMES-1:0] req,
    input  logic [ID_W-1:0]       ptr,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id
);

    logic [ID_W-1:0] cand0;
    logic [ID_W-1:0] cand1;
    logic [ID_W-1:0] cand2;

    always_comb begin
        cand0       = (ptr >= ID_W'(NUM_SLIMES)) ? '0 : ptr;
        cand1       = next_id(cand0);
        cand2       = next_id(cand1);
        grant_valid = |req;
        grant_id    = '0;
        if (req[cand0]) begin
            grant_id = cand0;
        end else if (req[cand1]) begin
            grant_id = cand1;
        end else if (req[cand2]) begin
            grant_id = cand2;
        end
    end

endmodule

// File: rtl/slim_death_sched.sv
// Serialises slime death animations through the single shared dead-slime sprite slot.
// Each slime runs its own lifecycle; pending kills are granted round-robin when the slot frees.
module slim_death_sched
    import slim_pkg::*;
#(
    parameter int TICKS_PER_STEP = 8,
    parameter int NUM_STEPS      = 7
)
(
    input  logic                 frame_clk,
    input  logic                 RESET,
    slim_death_sched_if.slave    bus
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

    slime_state_t          state_q [NUM_SLIMES];
    logic                  busy_q;
    logic [ID_W-1:0]       owner_q;
    logic [ID_W-1:0]       ptr_q;
    logic [STEP_W-1:0]     step_q;
    logic [TICK_W-1:0]     tick_q;
    logic                  done_q;

    logic [NUM_SLIMES-1:0] req;
    logic                  grant_valid;
    logic [ID_W-1:0]       grant_id;
    logic                  tick_wrap;
    logic                  last_tick;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SLIMES; i++) begin
            req[i] = (state_q[i] == PENDING);
        end
        tick_wrap = busy_q && (tick_q == TICK_LAST);
        last_tick = tick_wrap && (step_q == STEP_LAST);
    end

    slim_rr_arb u_arb (
        .req         (req),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Release and grant are mutually exclusive within one edge, which gives the
    // single idle cycle between back-to-back animations.
    always_ff @(posedge frame_clk or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_SLIMES; i++) begin
                state_q[i] <= ALIVE;
            end
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            step_q  <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else if (bus.level_start) begin
            for (int i = 0; i < NUM_SLIMES; i++) begin
                state_q[i] <= ALIVE;
            end
            busy_q  <= 1'b0;
            owner_q <= '0;
            step_q  <= '0;
            tick_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_tick;
            for (int i = 0; i < NUM_SLIMES; i++) begin
                if (state_q[i] == ALIVE && bus.kill[i]) begin
                    state_q[i] <= PENDING;
                end
            end
            if (busy_q) begin
                if (tick_wrap) begin
                    tick_q <= '0;
                    if (step_q == STEP_LAST) begin
                        state_q[owner_q] <= GONE;
                        busy_q           <= 1'b0;
                        owner_q          <= '0;
                        step_q           <= '0;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end else begin
                    tick_q <= tick_q + TICK_W'(1);
                end
            end else if (grant_valid) begin
                state_q[grant_id] <= DYING;
                busy_q            <= 1'b1;
                owner_q           <= grant_id;
                ptr_q             <= next_id(grant_id);
                step_q            <= '0;
                tick_q            <= '0;
            end
        end
    end

    always_comb begin
        bus.display = '0;
        bus.gone    = '0;
        for (int i = 0; i < NUM_SLIMES; i++) begin
            bus.display[i] = (state_q[i] == DYING);
            bus.gone[i]    = (state_q[i] == GONE);
        end
        bus.frame     = busy_q ? FRAME_MAP[step_q] : '0;
        bus.active_id = busy_q ? owner_q : '0;
        bus.anim_busy = busy_q;
        bus.anim_done = done_q;
    end

endmodule

// File: doc/slim_death_sched.md
Name: slim_death_sched

Overview:
- Schedules slime death animations for the three slimes on the tile map.
- Only one death animation plays at a time, because the dead-slime sprite ROM port and its palette are shared.
- Each slime has its own lifecycle FSM. Kills arriving while an animation is playing are queued and granted round-robin.
- Outputs feed the sprite-on/colour mapper: frame index, active slime id, per-slime display/gone flags.

Parameters:
- NUM_SLIMES, 3, number of slimes; the logic is written for 3.
- TICKS_PER_STEP, 8, frame_clk cycles per animation step (must be 1..63).
- NUM_STEPS, 7, animation steps per death; step-to-frame map is 0,0,1,1,2,3,4.

Ports:
- frame_clk  in  1  frame clock (one cycle per video frame)
- RESET  in  1  asynchronous, active-high reset
- level_start  in  1  synchronous pulse; all slimes return to ALIVE
- kill  in  3  per-slime kill pulse, bit i = slime i hit this cycle
- display  out  3  bit i high while slime i plays its death animation
- gone  out  3  bit i high once slime i's animation has completed
- frame  out  3  current death sprite frame 0..4; 0 when idle
- active_id  out  2  index of slime owning the animation slot; 0 when idle
- anim_busy  out  1  slot occupied
- anim_done  out  1  one-cycle pulse on the cycle the owner enters GONE

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is frame_clk.
  - All slimes go to ALIVE; the slot is freed; the round-robin pointer is set to 0; the step and tick counters clear.
  - All outputs are 0 in reset.
  - RESET mid-animation aborts the animation immediately, with no anim_done pulse.
- Per-slime FSM states: ALIVE, PENDING, DYING, GONE.
  - ALIVE -> PENDING when kill[i]=1.
  - kill[i] is ignored in PENDING, DYING and GONE.
  - PENDING -> DYING when the arbiter grants slime i.
  - DYING -> GONE on the last tick of step NUM_STEPS-1.
  - GONE holds until level_start or RESET.
- level_start (synchronous):
  - Forces all slimes to ALIVE, frees the slot, clears the counters; the round-robin pointer is kept.
  - Takes priority over kill and grant in the same cycle; anim_done is not pulsed.
- Arbitration:
  - Evaluated on registered state only. On an edge where the slot is free and at least one slime is PENDING, grant the first PENDING slime found scanning from ptr upward, mod 3.
  - After a grant to slime g, ptr becomes (g+1) mod 3.
  - Latency: a kill sampled at edge t sets PENDING. With the slot free, the grant occurs at edge t+1 and display rises after edge t+1.
- Slot release:
  - On the final tick the owner goes to GONE, anim_busy drops and anim_done pulses, all at the same edge.
  - The earliest next grant is the following edge. Back-to-back animations therefore have exactly one idle cycle between them.
- Counters:
  - tick counts 0..TICKS_PER_STEP-1; step increments when tick wraps.
  - DYING duration is NUM_STEPS*TICKS_PER_STEP cycles (56 at default).
  - frame = map[step] while busy, else 0. step never exceeds NUM_STEPS-1.
- Output relations: display[i] = (state==DYING); gone[i] = (state==GONE). At most one display bit is high at any time.
- Simultaneous events:
  - kill on multiple bits in one cycle: all of those slimes go PENDING, then are served in round-robin order.
  - A kill to the current owner is ignored.

Decomposition:
- slim_pkg holds:
  - the slime_state_t enum {ALIVE, PENDING, DYING, GONE};
  - NUM_SLIMES;
  - the FRAME_MAP constant array {0,0,1,1,2,3,4};
  - the step/tick width localparams.
- One sub-module, slim_rr_arb. It is combinational: req[3] plus ptr in, grant_valid and grant_id[1:0] out. The round-robin pointer register lives in the parent.

Test Plan:
- Reset then kill=3'b010 at cycle 5. Required response:
  - PENDING after edge 5; display=3'b010, active_id=1, anim_busy=1 after edge 6.
  - frame follows 0 (cycles 1-16), 1 (17-32), 2, 3, 4, changing every 8 cycles.
  - anim_done pulses 56 cycles after grant; gone=3'b010; frame returns to 0.
- kill=3'b111 in one cycle with ptr=0. Required response:
  - Slimes are served in the order 0, 1, 2, with exactly one idle cycle between animations.
  - Final gone=3'b111; total time 3*56+2 cycles after grant 0.
- With ptr=2 (after serving slime 1), kill=3'b011. Required response: slime 0 is granted before slime 1.
- During slime 0's DYING, pulse kill[0] again and pulse kill[2]. Required response:
  - kill[0] is ignored.
  - Slime 2 stays PENDING until slime 0 completes, then is granted on the following edge.
- Assert level_start mid-animation, in the same cycle as kill[1]. Required response:
  - All slimes return to ALIVE; display=0, gone=0, anim_busy=0.
  - No anim_done pulse; kill[1] is dropped.
- Assert RESET asynchronously mid-step, between clock edges. Required response:
  - All outputs go to 0 immediately.
  - After release, kill[2] grants slime 2 through ptr=0 scanning.
